// File: rtl/code_lock_fsm.sv
// -----------------------------------------------------------------------------
// code_lock_fsm
//
// Four-digit code lock. The user enters 2-bit digits one at a time, and each
// digit is compared against the matching digit of the live key input. A fully
// correct code opens the lock. A wrong code pulses bad_code and counts as a
// failure. MAX_FAILS consecutive failures put the lock into a timed lockout
// that lasts LOCKOUT_CYCLES clock cycles.
//
// Parameters
//   MAX_FAILS       consecutive wrong codes that trigger lockout (1..7)
//   LOCKOUT_CYCLES  lockout duration in clock cycles (1..255)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset, highest priority
//   digit_in     entered code digit
//   digit_valid  digit_in is offered this cycle
//   key          stored code; digit n = key[2n+1:2n], digit 0 entered first
//   relock       relock (OPEN) or abort a partial entry (WAIT)
//   unlocked     level, correct code accepted
//   bad_code     one-cycle pulse after a wrong 4-digit code
//   locked_out   level, lockout active
//   digit_idx    index of the next expected digit
//
// State  | meaning
// -------+---------------------------------------------------------------
// WAIT   | collecting digits, comparing each against the live key
// OPEN   | correct code accepted, unlocked held high until relock
// LOCKOUT| too many wrong codes; all input except reset is ignored
// -----------------------------------------------------------------------------
module code_lock_fsm #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] digit_in,
    input  logic       digit_valid,
    input  logic [7:0] key,
    input  logic       relock,
    output logic       unlocked,
    output logic       bad_code,
    output logic       locked_out,
    output logic [1:0] digit_idx
);

    // The timer counts down from LOCKOUT_CYCLES-1 to 0. It is sized to hold
    // LOCKOUT_CYCLES itself, so the load value can never wrap.
    localparam int                 TIMER_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         FAIL_LIMIT = 3'(MAX_FAILS);
    localparam logic [2:0]         FAIL_SAT   = 3'd7;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         idx_nxt;
    logic               mismatch;
    logic               mismatch_nxt;
    logic [2:0]         fail_cnt;
    logic [2:0]         fail_nxt;
    logic [2:0]         fail_inc;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               bad_nxt;
    logic [1:0]         key_digit;
    logic               code_wrong;

    // The key digit is selected from the live key, so a key change during
    // entry only affects digits that have not been accepted yet.
    always_comb begin
        key_digit = key[1:0];
        case (digit_idx)
            2'd0:    key_digit = key[1:0];
            2'd1:    key_digit = key[3:2];
            2'd2:    key_digit = key[5:4];
            default: key_digit = key[7:6];
        endcase
    end

    // The mismatch of the final digit is folded in here because it is not
    // yet in the sticky flag when the decision is made.
    assign code_wrong = mismatch | (digit_in != key_digit);

    // The fail counter saturates instead of wrapping.
    assign fail_inc = (fail_cnt == FAIL_SAT) ? FAIL_SAT : fail_cnt + 3'd1;

    always_comb begin
        state_nxt    = state;
        idx_nxt      = digit_idx;
        mismatch_nxt = mismatch;
        fail_nxt     = fail_cnt;
        timer_nxt    = timer;
        bad_nxt      = 1'b0;

        case (state)
            ST_WAIT: begin
                if (relock) begin
                    // Abort a partial entry. The fail count is unchanged.
                    idx_nxt      = 2'd0;
                    mismatch_nxt = 1'b0;
                end else if (digit_valid) begin
                    if (digit_idx == 2'd3) begin
                        idx_nxt      = 2'd0;
                        mismatch_nxt = 1'b0;
                        if (!code_wrong) begin
                            state_nxt = ST_OPEN;
                            fail_nxt  = 3'd0;
                        end else begin
                            bad_nxt  = 1'b1;
                            fail_nxt = fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                state_nxt = ST_LOCKOUT;
                                timer_nxt = TIMER_LOAD;
                            end
                        end
                    end else begin
                        idx_nxt      = digit_idx + 2'd1;
                        mismatch_nxt = code_wrong;
                    end
                end
            end

            ST_OPEN: begin
                if (relock) begin
                    state_nxt = ST_WAIT;
                end
            end

            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_nxt = ST_WAIT;
                    fail_nxt  = 3'd0;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end

            default: begin
                state_nxt    = ST_WAIT;
                idx_nxt      = 2'd0;
                mismatch_nxt = 1'b0;
                fail_nxt     = 3'd0;
                timer_nxt    = '0;
            end
        endcase
    end

    // The outputs are decoded from the next state, so each one is a flop
    // that is valid in the same cycle the state register changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_WAIT;
            digit_idx  <= 2'd0;
            mismatch   <= 1'b0;
            fail_cnt   <= 3'd0;
            timer      <= '0;
            unlocked   <= 1'b0;
            bad_code   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit_idx  <= idx_nxt;
            mismatch   <= mismatch_nxt;
            fail_cnt   <= fail_nxt;
            timer      <= timer_nxt;
            unlocked   <= (state_nxt == ST_OPEN);
            bad_code   <= bad_nxt;
            locked_out <= (state_nxt == ST_LOCKOUT);
        end
    end

endmodule
